c432_key_loader: RTL

C432_KEY_LOADER -- requirements
Module: c432_key_loader

---
 rtl/c432_key_pkg.sv | 21 ++
 rtl/c432_key_shreg.sv | 22 ++
 rtl/c432_key_loader.sv | 133 +++++++++++++
 3 files changed

// File: rtl/c432_key_pkg.sv
// rtl/c432_key_pkg.sv - shared types and constants for the c432 key loader
package c432_key_pkg;

  localparam int KEY_W_DEF = 24;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SHIFT = 3'd1,
    ST_CHECK = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } key_state_t;

  // Counter must reach KEY_W itself, hence the +1.
  function automatic int cnt_width(input int kw);
    return $clog2(kw + 1);
  endfunction

  localparam int KEY_CNT_W = cnt_width(KEY_W_DEF);

endpackage

// File: rtl/c432_key_shreg.sv
// rtl/c432_key_shreg.sv - indexed key shift register with clear and load-enable
module c432_key_shreg #(
  parameter int W     = 24,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic [IDX_W-1:0] idx,
  input  logic             d,
  output logic [W-1:0]     q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (load) begin
      q <= (q & ~(W'(1) << idx)) | (W'(d) << idx);
    end
  end

endmodule

// File: rtl/c432_key_loader.sv
// rtl/c432_key_loader.sv - serial key loader for the c432 core; KEY_PARITY_EN adds a parity check
module c432_key_loader
  import c432_key_pkg::*;
#(
  parameter int KEY_W = KEY_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clr,
  input  logic             bit_vld,
  input  logic             bit_in,
  output logic             bit_rdy,
  output logic [KEY_W-1:0] key,
  output logic             key_valid,
  output logic             key_err
);

  localparam int CNT_W = cnt_width(KEY_W);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(KEY_W - 1);

  key_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [KEY_W-1:0] sr_q;
  logic             restart;
  logic             sr_clr;
  logic             xfer;
  logic             sr_load;

  assign bit_rdy = (state == ST_SHIFT) || (state == ST_CHECK);
  // DONE holds the key locked, so start only restarts from the other states.
  assign restart = start && (state != ST_DONE);
  assign sr_clr  = !rst_n || clr || restart;
  assign xfer    = bit_vld && bit_rdy && !start && !clr;
  assign sr_load = xfer && (state == ST_SHIFT);

  c432_key_shreg #(
    .W     (KEY_W),
    .IDX_W (CNT_W)
  ) u_shreg (
    .clk  (clk),
    .clr  (sr_clr),
    .load (sr_load),
    .idx  (cnt),
    .d    (bit_in),
    .q    (sr_q)
  );

`ifdef KEY_PARITY_EN
  logic par_ok;
  assign par_ok = ((^sr_q) == bit_in);
`else
  // The last bit lands in sr_q on the same edge, so merge it in for the key load.
  logic [KEY_W-1:0] key_full;
  always_comb begin
    key_full            = sr_q;
    key_full[KEY_W-1]   = bit_in;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      key       <= '0;
      key_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_SHIFT;
            cnt   <= '0;
          end
        end
        ST_SHIFT: begin
          if (start) begin
            cnt <= '0;
          end else if (bit_vld) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST_IDX) begin
`ifdef KEY_PARITY_EN
              state <= ST_CHECK;
`else
              state     <= ST_DONE;
              key       <= key_full;
              key_valid <= 1'b1;
`endif
            end
          end
        end
`ifdef KEY_PARITY_EN
        ST_CHECK: begin
          if (start) begin
            state <= ST_SHIFT;
            cnt   <= '0;
          end else if (bit_vld) begin
            if (par_ok) begin
              state     <= ST_DONE;
              key       <= sr_q;
              key_valid <= 1'b1;
            end else begin
              state <= ST_ERR;
            end
          end
        end
        ST_ERR: begin
          if (start) begin
            state <= ST_SHIFT;
            cnt   <= '0;
          end
        end
`endif
        default: begin
        end
      endcase
    end
  end

`ifdef KEY_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      key_err <= 1'b0;
    end else if (state == ST_CHECK && xfer && !par_ok) begin
      key_err <= 1'b1;
    end else if (state == ST_ERR && start) begin
      key_err <= 1'b0;
    end
  end
`else
  assign key_err = 1'b0;
`endif

endmodule
